// File: rtl/neander_pkg.sv
// Shared definitions for the Neander processor: opcodes, ULA operation
// codes, control FSM states and opcode classification helpers.
package neander_pkg;

  // Instruction opcodes (upper nibble of the instruction byte)
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_STA = 4'h1;
  localparam logic [3:0] OP_LDA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_NOT = 4'h6;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JN  = 4'h9;
  localparam logic [3:0] OP_JZ  = 4'hA;
  localparam logic [3:0] OP_HLT = 4'hF;

  // ULA operation select codes
  localparam logic [2:0] ULA_ADD   = 3'b000;
  localparam logic [2:0] ULA_OR    = 3'b001;
  localparam logic [2:0] ULA_AND   = 3'b010;
  localparam logic [2:0] ULA_NOT   = 3'b011;
  localparam logic [2:0] ULA_PASSY = 3'b100;

  typedef enum logic [3:0] {
    S_FETCH_ADDR = 4'd0,
    S_FETCH_READ = 4'd1,
    S_FETCH_IR   = 4'd2,
    S_DECODE     = 4'd3,
    S_OP_ADDR    = 4'd4,
    S_OP_READ    = 4'd5,
    S_EA         = 4'd6,
    S_DATA_READ  = 4'd7,
    S_EXEC       = 4'd8,
    S_STORE_LD   = 4'd9,
    S_STORE_WR   = 4'd10,
    S_JUMP       = 4'd11,
    S_SKIP       = 4'd12,
    S_HALT       = 4'd13
  } state_t;

  // Opcodes that always fetch an address operand byte after the opcode
  function automatic logic needs_operand(input logic [3:0] op);
    return (op == OP_STA) || (op == OP_LDA) || (op == OP_ADD) ||
           (op == OP_OR)  || (op == OP_AND) || (op == OP_JMP);
  endfunction

  // Opcodes whose operand byte is a jump target rather than a data address
  function automatic logic is_jump(input logic [3:0] op);
    return (op == OP_JMP) || (op == OP_JN) || (op == OP_JZ);
  endfunction

  // ULA operation used when the accumulator is written back
  function automatic logic [2:0] ula_op(input logic [3:0] op);
    logic [2:0] sel;
    case (op)
      OP_OR:   sel = ULA_OR;
      OP_AND:  sel = ULA_AND;
      OP_NOT:  sel = ULA_NOT;
      OP_LDA:  sel = ULA_PASSY;
      default: sel = ULA_ADD;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/neander_control.sv
// Neander control unit: Moore FSM sequencing fetch, decode and execute of
// one instruction at a time, plus a count of decoded instructions.
// Control outputs decode from the state register only (run gates the fetch
// address load, opcode selects the ULA operation in S_EXEC).
// dbg_state exposes the current state for checkers.
module neander_control
  import neander_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [3:0]       opcode,
  input  logic             n_flag,
  input  logic             z_flag,
  output logic             pc_load,
  output logic             pc_inc,
  output logic             rem_load,
  output logic             rem_sel,
  output logic             rdm_load,
  output logic             rdm_sel,
  output logic             mem_write,
  output logic             ri_load,
  output logic             ac_load,
  output logic             nz_load,
  output logic [2:0]       sel_ula,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count,
  output logic [3:0]       dbg_state
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Next-state and counter logic; flags are only looked at in S_DECODE
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      S_FETCH_ADDR: if (run) state_d = S_FETCH_READ;
      S_FETCH_READ: state_d = S_FETCH_IR;
      S_FETCH_IR:   state_d = S_DECODE;
      S_DECODE: begin
        count_d = count_q + CNT_W'(1);
        case (opcode)
          OP_NOT:  state_d = S_EXEC;
          OP_HLT:  state_d = S_HALT;
          OP_JN:   state_d = n_flag ? S_OP_ADDR : S_SKIP;
          OP_JZ:   state_d = z_flag ? S_OP_ADDR : S_SKIP;
          default: state_d = needs_operand(opcode) ? S_OP_ADDR : S_FETCH_ADDR;
        endcase
      end
      S_OP_ADDR:    state_d = S_OP_READ;
      S_OP_READ:    state_d = is_jump(opcode) ? S_JUMP : S_EA;
      S_EA:         state_d = (opcode == OP_STA) ? S_STORE_LD : S_DATA_READ;
      S_DATA_READ:  state_d = S_EXEC;
      S_STORE_LD:   state_d = S_STORE_WR;
      S_EXEC, S_STORE_WR, S_JUMP, S_SKIP: state_d = S_FETCH_ADDR;
      S_HALT:       state_d = S_HALT;
      default:      state_d = S_FETCH_ADDR;
    endcase
  end

  // State and counter registers, cleared asynchronously by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH_ADDR;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Moore output decode: everything low / ULA_ADD unless the state asserts it
  always_comb begin
    pc_load   = 1'b0;
    pc_inc    = 1'b0;
    rem_load  = 1'b0;
    rem_sel   = 1'b0;
    rdm_load  = 1'b0;
    rdm_sel   = 1'b0;
    mem_write = 1'b0;
    ri_load   = 1'b0;
    ac_load   = 1'b0;
    nz_load   = 1'b0;
    sel_ula   = ULA_ADD;
    halted    = 1'b0;
    case (state_q)
      S_FETCH_ADDR: rem_load = run;
      S_FETCH_READ: begin rdm_load = 1'b1; pc_inc = 1'b1; end
      S_FETCH_IR:   ri_load = 1'b1;
      S_OP_ADDR:    rem_load = 1'b1;
      S_OP_READ:    begin rdm_load = 1'b1; pc_inc = 1'b1; end
      S_EA:         begin rem_load = 1'b1; rem_sel = 1'b1; end
      S_DATA_READ:  rdm_load = 1'b1;
      S_EXEC: begin
        ac_load = 1'b1;
        nz_load = 1'b1;
        sel_ula = ula_op(opcode);
      end
      S_STORE_LD:   begin rdm_load = 1'b1; rdm_sel = 1'b1; end
      S_STORE_WR:   mem_write = 1'b1;
      S_JUMP:       pc_load = 1'b1;
      S_SKIP:       pc_inc = 1'b1;
      S_HALT:       halted = 1'b1;
      default:      ;
    endcase
  end

  assign instr_count = count_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_neander_control.sv
// Bench for neander_control: a micro-operation reference model expands each
// instruction into its per-cycle control pattern, pushed on an expected
// queue; a negedge monitor pops and compares every cycle.
module tb_neander_control;

  localparam int CW = 4;

  // Micro-operation masks: {pc_load,pc_inc,rem_load,rem_sel,rdm_load,
  // rdm_sel,mem_write,ri_load,ac_load,nz_load,sel_ula[2:0]}
  localparam logic [12:0] U_NONE     = 13'h0000;
  localparam logic [12:0] U_REM_PC   = 13'b0_0_1_0_0_0_0_0_0_0_000;
  localparam logic [12:0] U_RD_PCINC = 13'b0_1_0_0_1_0_0_0_0_0_000;
  localparam logic [12:0] U_IR       = 13'b0_0_0_0_0_0_0_1_0_0_000;
  localparam logic [12:0] U_REM_RDM  = 13'b0_0_1_1_0_0_0_0_0_0_000;
  localparam logic [12:0] U_RD_MEM   = 13'b0_0_0_0_1_0_0_0_0_0_000;
  localparam logic [12:0] U_RD_AC    = 13'b0_0_0_0_1_1_0_0_0_0_000;
  localparam logic [12:0] U_WRITE    = 13'b0_0_0_0_0_0_1_0_0_0_000;
  localparam logic [12:0] U_PC_RDM   = 13'b1_0_0_0_0_0_0_0_0_0_000;
  localparam logic [12:0] U_PC_INC   = 13'b0_1_0_0_0_0_0_0_0_0_000;
  localparam logic [12:0] U_AC_WB    = 13'b0_0_0_0_0_0_0_0_1_1_000;

  localparam int VW = 13 + 1 + CW;

  logic          clk = 1'b0;
  logic          rst;
  logic          run;
  logic [3:0]    opcode;
  logic          n_flag, z_flag;
  logic          pc_load, pc_inc, rem_load, rem_sel, rdm_load, rdm_sel;
  logic          mem_write, ri_load, ac_load, nz_load, halted;
  logic [2:0]    sel_ula;
  logic [CW-1:0] instr_count;
  logic [3:0]    dbg_state;

  logic [VW-1:0] exp_q[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  logic [CW-1:0] m_count;
  logic          m_halted;

  neander_control #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode),
    .n_flag(n_flag), .z_flag(z_flag),
    .pc_load(pc_load), .pc_inc(pc_inc), .rem_load(rem_load), .rem_sel(rem_sel),
    .rdm_load(rdm_load), .rdm_sel(rdm_sel), .mem_write(mem_write),
    .ri_load(ri_load), .ac_load(ac_load), .nz_load(nz_load),
    .sel_ula(sel_ula), .halted(halted), .instr_count(instr_count),
    .dbg_state(dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d expected left", exp_q.size());
    $fatal(1, "watchdog");
  end

  function automatic logic [VW-1:0] outs();
    return {pc_load, pc_inc, rem_load, rem_sel, rdm_load, rdm_sel, mem_write,
            ri_load, ac_load, nz_load, sel_ula, halted, instr_count};
  endfunction

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: actual=%b required=%b (state=%0d)", name, $time, act, exp, dbg_state);
    end
  endtask

  // Monitor: one expected entry per clock cycle while the queue is non-empty
  always @(negedge clk) begin
    if (exp_q.size() > 0) check("cycle_outputs", outs(), exp_q.pop_front());
  end

  function automatic logic [2:0] alu_code(input logic [3:0] op);
    case (op)
      4'h2:    return 3'b100;
      4'h4:    return 3'b001;
      4'h5:    return 3'b010;
      4'h6:    return 3'b011;
      default: return 3'b000;
    endcase
  endfunction

  // Reference model: expands one instruction into its micro-op sequence and
  // pushes the first max_cyc cycles onto the expected queue.
  task automatic model_instr(input logic [3:0] op, input logic n, input logic z,
                             input int max_cyc, output int len);
    logic [12:0] steps[$];
    logic        taken;
    steps = {U_REM_PC, U_RD_PCINC, U_IR, U_NONE};
    taken = (op == 4'h8) || (op == 4'h9 && n) || (op == 4'hA && z);
    if (op == 4'h6) steps.push_back(U_AC_WB | 13'(alu_code(op)));
    else if (op == 4'h9 || op == 4'hA || op == 4'h8) begin
      if (taken) steps = {steps, U_REM_PC, U_RD_PCINC, U_PC_RDM};
      else       steps.push_back(U_PC_INC);
    end else if (op == 4'h1)
      steps = {steps, U_REM_PC, U_RD_PCINC, U_REM_RDM, U_RD_AC, U_WRITE};
    else if (op >= 4'h2 && op <= 4'h5)
      steps = {steps, U_REM_PC, U_RD_PCINC, U_REM_RDM, U_RD_MEM,
               U_AC_WB | 13'(alu_code(op))};
    len = (steps.size() < max_cyc) ? steps.size() : max_cyc;
    for (int i = 0; i < len; i++)
      exp_q.push_back({steps[i], 1'b0, (i <= 3) ? m_count : m_count + CW'(1)});
    if (len > 3) begin
      m_count = m_count + CW'(1);
      if (op == 4'hF) m_halted = 1'b1;
    end
  endtask

  // Driver: run one instruction; opcode valid from decode on, flags only
  // meaningful in the decode cycle, run random outside the fetch cycle.
  task automatic do_instr(input logic [3:0] op, input logic n, input logic z,
                          input int max_cyc = 100);
    int len;
    model_instr(op, n, z, max_cyc, len);
    for (int c = 0; c < len; c++) begin
      run    = (c == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      opcode = (c >= 3) ? op : 4'($urandom_range(0, 15));
      n_flag = (c == 3) ? n : 1'($urandom_range(0, 1));
      z_flag = (c == 3) ? z : 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
  endtask

  task automatic idle_cycle(input logic r);
    run    = r;
    opcode = 4'($urandom_range(0, 15));
    n_flag = 1'($urandom_range(0, 1));
    z_flag = 1'($urandom_range(0, 1));
    exp_q.push_back({13'h0, m_halted, m_count});
    @(posedge clk); #1;
  endtask

  // Asynchronous reset asserted mid-cycle, released mid-cycle
  task automatic apply_reset();
    run = 1'b0;
    rst = 1'b0;
    m_count  = '0;
    m_halted = 1'b0;
    #1;
    check("async_reset_now", outs(), '0);
    exp_q.push_back('0);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.push_back('0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b0; run = 1'b0; opcode = '0; n_flag = 1'b0; z_flag = 1'b0;
    m_count = '0; m_halted = 1'b0;
    @(posedge clk); #1;
    apply_reset();

    // Directed: each instruction class, both branch outcomes
    do_instr(4'h2, 1'b0, 1'b0);   // LDA
    do_instr(4'h1, 1'b1, 1'b1);   // STA
    do_instr(4'h9, 1'b0, 1'b1);   // JN not taken
    do_instr(4'h9, 1'b1, 1'b0);   // JN taken
    do_instr(4'hA, 1'b1, 1'b0);   // JZ not taken
    do_instr(4'hA, 1'b0, 1'b1);   // JZ taken
    do_instr(4'h8, 1'b0, 1'b0);   // JMP
    do_instr(4'h6, 1'b0, 1'b0);   // NOT
    do_instr(4'h3, 1'b0, 1'b0);   // ADD
    do_instr(4'h4, 1'b0, 1'b0);   // OR
    do_instr(4'h5, 1'b0, 1'b0);   // AND
    do_instr(4'h0, 1'b0, 1'b0);   // NOP
    do_instr(4'hC, 1'b0, 1'b0);   // undefined
    idle_cycle(1'b0);
    idle_cycle(1'b0);

    // Randomized instruction stream with idle gaps (no HLT here)
    for (int i = 0; i < 150; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 14));
      if ($urandom_range(0, 3) == 0) begin
        for (int k = 0; k < int'($urandom_range(1, 3)); k++) idle_cycle(1'b0);
      end
      do_instr(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Counter wrap: 17 NOPs from reset on a 4-bit counter
    apply_reset();
    for (int i = 0; i < 17; i++) do_instr(4'h0, 1'b0, 1'b0);
    check("wrap_count", {{(VW-CW){1'b0}}, instr_count}, {{(VW-CW){1'b0}}, CW'(1)});

    // Reset in the middle of a store (cycle 7 = RDM <- AC)
    do_instr(4'h1, 1'b0, 1'b0, 7);
    apply_reset();
    do_instr(4'h2, 1'b0, 1'b0);   // fetch resumes after reset
    idle_cycle(1'b0);

    // Halt: run toggling has no effect, count stays at 1
    apply_reset();
    do_instr(4'hF, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) idle_cycle(1'(i % 2));
    check("halt_count", {{(VW-CW-1){1'b0}}, halted, instr_count},
          {{(VW-CW-1){1'b0}}, 1'b1, CW'(1)});

    @(negedge clk); #1;
    check("queue_drained", VW'(exp_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
